// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode/func constants, fetch state type and helpers.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Sign-extended word offset of a branch immediate, in bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_logic
// Description : Combinational next-PC target selection and jr alignment check.
// Revision    : 1.0
// ============================================================================
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target_field,
    input  logic        branch,
    input  logic        bneq,
    input  logic        jump,
    input  logic        jr,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic w_taken;

    assign w_taken    = branch & (bneq ? ~alu_zero : alu_zero);
    assign misaligned = jr & (rs_data[1:0] != 2'b00);

    // jr outranks jump, which outranks branch, whatever the decoder asserts.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], target_field, 2'b00};
        end else if (w_taken) begin
            next_pc = pc_plus4 + branch_offset(target_field[15:0]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: PC, imem handshake, next-PC update.
// Revision    : 1.0
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        branch,
    input  logic        bneq,
    input  logic        jump,
    input  logic        jr,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic        fault,
    output logic [31:0] retired_count
);

    localparam logic [15:0] c_TMO_LAST = 16'(FETCH_TIMEOUT - 1);

    fetch_state_t r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic [31:0]  r_instr, w_instr_next;
    logic [31:0]  r_count, w_count_next;
    logic         r_fault, w_fault_next;
    logic [15:0]  r_tmo, w_tmo_next;
    logic         r_active;
    logic [31:0]  w_target;
    logic         w_misaligned;

    next_pc_logic u_next_pc (
        .pc_plus4     (pc_plus4),
        .target_field (r_instr[25:0]),
        .branch       (branch),
        .bneq         (bneq),
        .jump         (jump),
        .jr           (jr),
        .alu_zero     (alu_zero),
        .rs_data      (rs_data),
        .next_pc      (w_target),
        .misaligned   (w_misaligned)
    );

    // r_active holds the request low for the cycle right after reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_count  <= 32'd0;
            r_fault  <= 1'b0;
            r_tmo    <= 16'd0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_instr  <= w_instr_next;
            r_count  <= w_count_next;
            r_fault  <= w_fault_next;
            r_tmo    <= w_tmo_next;
            r_active <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_count_next = r_count;
        w_fault_next = r_fault;
        w_tmo_next   = r_tmo;
        case (r_state)
            FETCH: begin
                if (r_active) begin
                    if (imem_ready) begin
                        w_instr_next = imem_rdata;
                        w_state_next = HOLD;
                        w_tmo_next   = 16'd0;
                    end else if (r_tmo == c_TMO_LAST) begin
                        w_fault_next = 1'b1;
                        w_state_next = HALT;
                    end else begin
                        w_tmo_next = r_tmo + 16'd1;
                    end
                end
            end
            HOLD: begin
                if (retire) begin
                    if (w_misaligned) begin
                        w_fault_next = 1'b1;
                        w_state_next = HALT;
                    end else begin
                        w_pc_next    = w_target;
                        w_count_next = r_count + 32'd1;
                        w_state_next = FETCH;
                    end
                end
            end
            HALT: begin
                w_fault_next = 1'b1;
            end
            default: begin
                w_state_next = HALT;
                w_fault_next = 1'b1;
            end
        endcase
    end

    assign imem_req      = r_active && (r_state == FETCH);
    assign imem_addr     = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = (r_state == HOLD);
    assign opcode        = r_instr[31:26];
    assign func          = r_instr[5:0];
    assign pc            = r_pc;
    assign pc_plus4      = r_pc + 32'd4;
    assign fault         = r_fault;
    assign retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit (vectors, random, corners).
// Revision    : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode, func;
    logic [31:0] pc, pc_plus4;
    logic        retire = 1'b0, branch = 1'b0, bneq = 1'b0, jump = 1'b0, jr = 1'b0, alu_zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        fault;
    logic [31:0] retired_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] mpc, mcount, minstr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .opcode(opcode), .func(func), .pc(pc),
        .pc_plus4(pc_plus4), .retire(retire), .branch(branch), .bneq(bneq),
        .jump(jump), .jr(jr), .alu_zero(alu_zero), .rs_data(rs_data),
        .fault(fault), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] word;
        logic        br, bn, jp, jrr, z;
        logic [31:0] rs;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference next-PC computed directly from the ISA rules.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic bn, input logic j,
                                             input logic r, input logic z, input logic [31:0] rs);
        logic signed [31:0] off;
        logic [31:0] seq;
        seq = p + 32'd4;
        off = {{16{w[15]}}, w[15:0]};
        if (r) return rs;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
        if (b && (bn ? !z : z)) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b0; retire = 1'b0;
        tick(); tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_count", retired_count, 32'd0);
        reset = 1'b0;
        tick();
        check("req_after_rst", {31'd0, imem_req}, 32'd1);
        mpc = 32'h0; mcount = 32'd0; minstr = 32'd0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] word, input int lat);
        wait_req();
        check("imem_addr", imem_addr, mpc);
        for (int i = 0; i < lat; i++) begin
            imem_ready = 1'b0;
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        minstr = word;
        check("valid", {31'd0, instr_valid}, 32'd1);
        check("instr", instr, word);
        check("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
        check("func", {26'd0, func}, {26'd0, word[5:0]});
        check("pc_plus4", pc_plus4, mpc + 32'd4);
    endtask

    task automatic do_retire(input int dly, input logic b, input logic bn, input logic j,
                             input logic r, input logic z, input logic [31:0] rs);
        for (int i = 0; i < dly; i++) begin
            imem_ready = 1'($urandom % 2);
            imem_rdata = $urandom;
            tick();
            check("hold_instr", instr, minstr);
            check("hold_pc", pc, mpc);
        end
        imem_ready = 1'b0;
        branch = b; bneq = bn; jump = j; jr = r; alu_zero = z; rs_data = rs; retire = 1'b1;
        tick();
        retire = 1'b0; branch = 1'b0; bneq = 1'b0; jump = 1'b0; jr = 1'b0;
        mpc = ref_next(mpc, minstr, b, bn, j, r, z, rs);
        mcount = mcount + 32'd1;
        check("next_pc", pc, mpc);
        check("count", retired_count, mcount);
        check("refetch_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic goto_pc(input logic [31:0] target);
        do_fetch(32'h03E0_0008, 0);
        do_retire(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, target);
    endtask

    initial begin
        vecs[0] = '{32'h10, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0C};
        vecs[1] = '{32'h10, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h14};
        vecs[2] = '{32'h10, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h14};
        vecs[3] = '{32'h10, 32'h1400_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0C};
        vecs[4] = '{32'h4000_0020, 32'h0C00_0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4000_0400};
        vecs[5] = '{32'h200, 32'h1000_0005, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h80};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[7] = '{32'h100, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h110};
        vecs[8] = '{32'hF000_0000, 32'h0800_0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hF000_0100};

        // Sequential fetch from reset
        do_reset();
        for (int k = 0; k < 3; k++) begin
            do_fetch(32'h0000_0020, 2);
            do_retire(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        wait_req();
        check("seq_addr4", imem_addr, 32'd12);
        check("seq_count", retired_count, 32'd3);

        // Directed control-flow vectors
        foreach (vecs[i]) begin
            goto_pc(vecs[i].start_pc);
            do_fetch(vecs[i].word, 1);
            do_retire(1, vecs[i].br, vecs[i].bn, vecs[i].jp, vecs[i].jrr, vecs[i].z, vecs[i].rs);
            check("vec_pc", pc, vecs[i].exp_pc);
        end

        // Randomized traffic against the reference model
        for (int it = 0; it < 200; it++) begin
            logic [31:0] w, rs;
            logic r;
            w  = $urandom;
            r  = ($urandom % 8) == 0;
            rs = $urandom & 32'hFFFF_FFFC;
            do_fetch(w, int'($urandom % 3));
            do_retire(int'($urandom % 4), 1'($urandom), 1'($urandom), ($urandom % 4) == 0,
                      r, 1'($urandom), rs);
        end

        // Misaligned jr halts without retiring
        do_fetch(32'h03E0_0008, 0);
        jr = 1'b1; jump = 1'b1; branch = 1'b1; rs_data = 32'h0000_0082; retire = 1'b1;
        tick();
        retire = 1'b0; jr = 1'b0; jump = 1'b0; branch = 1'b0;
        check("jr_fault", {31'd0, fault}, 32'd1);
        check("jr_req", {31'd0, imem_req}, 32'd0);
        check("jr_valid", {31'd0, instr_valid}, 32'd0);
        check("jr_pc", pc, mpc);
        check("jr_count", retired_count, mcount);
        imem_ready = 1'b1; retire = 1'b1;
        tick(); tick();
        imem_ready = 1'b0; retire = 1'b0;
        check("halt_stays", {31'd0, fault}, 32'd1);
        check("halt_pc", pc, mpc);
        check("halt_instr", instr, minstr);

        // Fetch timeout
        do_reset();
        begin
            int n = 0;
            int guard = 0;
            while (!fault && guard < 30) begin
                if (imem_req) n++;
                tick();
                guard++;
            end
            check("tmo_cycles", n, 32'd4);
        end
        check("tmo_fault", {31'd0, fault}, 32'd1);
        check("tmo_req", {31'd0, imem_req}, 32'd0);
        tick(); tick();
        check("tmo_req_later", {31'd0, imem_req}, 32'd0);
        do_reset();
        check("tmo_cleared", {31'd0, fault}, 32'd0);

        // Reset collides with a ready response
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("rstmid_instr", instr, 32'h0);
        check("rstmid_valid", {31'd0, instr_valid}, 32'd0);
        reset = 1'b0; imem_ready = 1'b0;
        tick();

        // Stray retire while fetching
        retire = 1'b1; jr = 1'b1; jump = 1'b1; rs_data = 32'h44;
        tick();
        retire = 1'b0; jr = 1'b0; jump = 1'b0;
        check("fetch_retire_pc", pc, 32'h0);
        check("fetch_retire_cnt", retired_count, 32'd0);
        check("fetch_retire_req", {31'd0, imem_req}, 32'd1);
        mpc = 32'h0;
        do_fetch(32'h2000_0001, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
